// File: rtl/zigzag_reorder_buf_pkg.sv
// Shared types and constant functions for the zigzag reorder buffer.
// zz_addr/zz_pos walk the JPEG zigzag path and serve both 4x4 and 8x8 blocks.
package zigzag_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic bit dim_legal(input int dim);
        return (dim == 4) || (dim == 8);
    endfunction

    // Raster address of the k-th coefficient in zigzag order.
    function automatic int zz_addr(input int dim, input int k);
        int r;
        int c;
        r = 0;
        c = 0;
        for (int n = 0; n < k; n++) begin
            if (((r + c) % 2) == 0) begin
                if (c == dim - 1)  r = r + 1;
                else if (r == 0)   c = c + 1;
                else begin
                    r = r - 1;
                    c = c + 1;
                end
            end else begin
                if (r == dim - 1)  c = c + 1;
                else if (c == 0)   r = r + 1;
                else begin
                    r = r + 1;
                    c = c - 1;
                end
            end
        end
        return r * dim + c;
    endfunction

    // Zigzag position of raster address a (inverse of zz_addr).
    function automatic int zz_pos(input int dim, input int a);
        int pos;
        pos = 0;
        for (int k = 0; k < dim * dim; k++) begin
            if (zz_addr(dim, k) == a) pos = k;
        end
        return pos;
    endfunction

endpackage

// File: rtl/zigzag_reorder_buf_if.sv
// Raster-in / zigzag-out stream bundle; slave is the reorder buffer, master the surrounding datapath.
// out_eob/out_zero exist only when ZIGZAG_EOB_EN is defined.
interface zigzag_reorder_buf_if #(
    parameter int WIDTH = 12,
    parameter int DIM   = 8,
    parameter int IDXW  = $clog2(DIM * DIM)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
`ifdef ZIGZAG_EOB_EN
    logic [IDXW-1:0]  out_eob;
    logic             out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_eob, out_zero
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_eob, out_zero
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
`endif
endinterface

// File: rtl/zigzag_reorder_buf_bank.sv
// One coefficient bank: synchronous write, combinational read.
// Contents are don't-care after reset; bank state lives in the parent.
module zigzag_bank #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/zigzag_reorder_buf.sv
// Ping-pong raster->zigzag reorder; first output 2 cycles after a block's last input, zero bubbles between blocks.
// in_ready depends only on bank state; output register holds while out_ready is low. ZIGZAG_EOB_EN adds out_eob/out_zero.
module zigzag_reorder_buf
    import zigzag_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DIM   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    zigzag_reorder_buf_if.slave bus
);
    localparam int              N    = DIM * DIM;
    localparam int              IDXW = $clog2(N);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    if (!dim_legal(DIM)) begin : g_dim_check
        $error("zigzag_reorder_buf: DIM must be 4 or 8");
    end

    bank_state_e      state [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [IDXW-1:0]  wr_cnt;
    logic [IDXW-1:0]  rd_cnt;
    logic [IDXW-1:0]  zz_lut [N];
    logic [IDXW-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data [2];
    logic             wr_fire;
    logic             rd_avail;
    logic             load;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IDXW-1:0]  out_idx_q;
    logic             out_last_q;

    for (genvar g = 0; g < N; g++) begin : g_zz_lut
        localparam logic [IDXW-1:0] ADDR = IDXW'(zz_addr(DIM, g));
        assign zz_lut[g] = ADDR;
    end

    assign bus.in_ready = (state[wr_bank] == BANK_EMPTY) || (state[wr_bank] == BANK_FILLING);
    assign wr_fire      = bus.in_valid && bus.in_ready;
    assign rd_avail     = (state[rd_bank] == BANK_FULL) || (state[rd_bank] == BANK_DRAINING);
    assign load         = (!out_valid_q || bus.out_ready) && rd_avail;
    assign rd_addr      = zz_lut[rd_cnt];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        zigzag_bank #(
            .WIDTH (WIDTH),
            .DEPTH (N),
            .AW    (IDXW)
        ) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank == 1'(b))),
            .waddr (wr_cnt),
            .wdata (bus.in_data),
            .raddr (rd_addr),
            .rdata (rd_data[b])
        );
    end

    // Writer and reader never own the same bank, so their state updates cannot collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state[0]    <= BANK_EMPTY;
            state[1]    <= BANK_EMPTY;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_cnt == LAST) begin
                    state[wr_bank] <= BANK_FULL;
                    wr_cnt         <= '0;
                    wr_bank        <= ~wr_bank;
                end else begin
                    state[wr_bank] <= BANK_FILLING;
                    wr_cnt         <= wr_cnt + IDXW'(1);
                end
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rd_data[rd_bank];
                out_idx_q   <= rd_cnt;
                out_last_q  <= (rd_cnt == LAST);
                if (rd_cnt == LAST) begin
                    state[rd_bank] <= BANK_EMPTY;
                    rd_cnt         <= '0;
                    rd_bank        <= ~rd_bank;
                end else begin
                    state[rd_bank] <= BANK_DRAINING;
                    rd_cnt         <= rd_cnt + IDXW'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

`ifdef ZIGZAG_EOB_EN
    logic [IDXW-1:0] pos_lut [N];
    logic [IDXW-1:0] acc_eob;
    logic [IDXW-1:0] beat_eob;
    logic [IDXW-1:0] bank_eob [2];
    logic [IDXW-1:0] out_eob_q;
    logic            acc_nz;
    logic            beat_nz;
    logic            bank_zero [2];
    logic            out_zero_q;

    for (genvar g = 0; g < N; g++) begin : g_pos_lut
        localparam logic [IDXW-1:0] POS = IDXW'(zz_pos(DIM, g));
        assign pos_lut[g] = POS;
    end

    // Raster arrival is not monotonic in zigzag position, so keep a running maximum.
    assign beat_nz  = |bus.in_data;
    assign beat_eob = (beat_nz && (pos_lut[wr_cnt] > acc_eob)) ? pos_lut[wr_cnt] : acc_eob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_eob      <= '0;
            acc_nz       <= 1'b0;
            bank_eob[0]  <= '0;
            bank_eob[1]  <= '0;
            bank_zero[0] <= 1'b0;
            bank_zero[1] <= 1'b0;
            out_eob_q    <= '0;
            out_zero_q   <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_cnt == LAST) begin
                    bank_eob[wr_bank]  <= beat_eob;
                    bank_zero[wr_bank] <= !(acc_nz || beat_nz);
                    acc_eob            <= '0;
                    acc_nz             <= 1'b0;
                end else begin
                    acc_eob <= beat_eob;
                    acc_nz  <= acc_nz || beat_nz;
                end
            end
            if (load) begin
                out_eob_q  <= bank_eob[rd_bank];
                out_zero_q <= bank_zero[rd_bank];
            end
        end
    end

    assign bus.out_eob  = out_eob_q;
    assign bus.out_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// Bench for zigzag_reorder_buf: DIM=8 and DIM=4 instances against a diagonal-walk zigzag model.
// Build with ZIGZAG_EOB_EN defined to also exercise out_eob/out_zero.
module tb_zigzag_reorder_buf;
    localparam int W = 12;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        bit           last;
        int           eob;
        bit           zero;
        int           cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    zigzag_reorder_buf_if #(.WIDTH(W), .DIM(8)) bus8 ();
    zigzag_reorder_buf_if #(.WIDTH(W), .DIM(4)) bus4 ();

    zigzag_reorder_buf #(.WIDTH(W), .DIM(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    zigzag_reorder_buf #(.WIDTH(W), .DIM(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    rec_t         got8 [$];
    rec_t         exp8 [$];
    rec_t         got4 [$];
    logic [W-1:0] blk8 [64];
    int           acc8 = 0;
    int           last_acc8 = 0;
    bit           push_done = 0;

    always @(negedge clk) begin
        rec_t r;
        r.data = bus8.out_data;
        r.idx  = int'(bus8.out_idx);
        r.last = bus8.out_last;
        r.cyc  = cyc;
`ifdef ZIGZAG_EOB_EN
        r.eob  = int'(bus8.out_eob);
        r.zero = bus8.out_zero;
`else
        r.eob  = 0;
        r.zero = 1'b0;
`endif
        if (rst_n && bus8.out_valid && bus8.out_ready) got8.push_back(r);
    end

    always @(negedge clk) begin
        rec_t r;
        r.data = bus4.out_data;
        r.idx  = int'(bus4.out_idx);
        r.last = bus4.out_last;
        r.cyc  = cyc;
        r.eob  = 0;
        r.zero = 1'b0;
        if (rst_n && bus4.out_valid && bus4.out_ready) got4.push_back(r);
    end

    // Zigzag order as a walk over anti-diagonals: odd diagonals run down-left, even ones up-right.
    function automatic int ref_zz(input int dim, input int k);
        int n;
        n = 0;
        for (int s = 0; s <= 2 * dim - 2; s++) begin
            for (int i = 0; i < dim; i++) begin
                int r;
                int c;
                r = (s % 2 == 1) ? i : dim - 1 - i;
                c = s - r;
                if (c >= 0 && c < dim) begin
                    if (n == k) return r * dim + c;
                    n++;
                end
            end
        end
        return -1;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_block8();
        int eob;
        bit nz;
        eob = 0;
        nz  = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (blk8[ref_zz(8, k)] != '0) begin
                eob = k;
                nz  = 1'b1;
            end
        end
        for (int k = 0; k < 64; k++) begin
            rec_t e;
            e.data = blk8[ref_zz(8, k)];
            e.idx  = k;
            e.last = (k == 63);
            e.eob  = eob;
            e.zero = !nz;
            e.cyc  = 0;
            exp8.push_back(e);
        end
    endtask

    task automatic push8(input logic [W-1:0] d, output int waited);
        waited = 0;
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        @(negedge clk);
        while (!bus8.in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (bus8.in_ready) begin
            acc8++;
            last_acc8 = cyc;
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic send_block8(input int gap_max, output int max_wait);
        int w;
        max_wait = 0;
        expect_block8();
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, gap_max)) align();
            push8(blk8[i], w);
            if (w > max_wait) max_wait = w;
        end
    endtask

    task automatic drain8(input int n, output bit ok);
        int t;
        t = 0;
        while (got8.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        ok = (got8.size() == n);
    endtask

    task automatic clear8();
        got8.delete();
        exp8.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b out_last=%b, want 1 0 0", bus8.in_ready, bus8.out_valid, bus8.out_last);
        end
        n_checks++;
        if (bus8.out_data !== '0 || bus8.out_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%0h out_idx=%0d, want 0 0", bus8.out_data, bus8.out_idx);
        end
        n_checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dim4: in_ready=%b out_valid=%b, want 1 0", bus4.in_ready, bus4.out_valid);
        end
`ifdef ZIGZAG_EOB_EN
        n_checks++;
        if (bus8.out_eob !== '0 || bus8.out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_eob: out_eob=%0d out_zero=%b, want 0 0", bus8.out_eob, bus8.out_zero);
        end
`endif
        align();
        rst_n = 1'b1;
    endtask

    task automatic test_raster8();
        int w;
        bit ok;
        int head [10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
        align();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk8[i] = W'(i);
        send_block8(0, w);
        drain8(64, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL raster8_count: got %0d outputs, want 64", got8.size());
        end else begin
            n_checks++;
            if (got8[0].cyc != last_acc8 + 2) begin
                n_fail++;
                $display("FAIL raster8_latency: first out_valid in cycle %0d, want %0d", got8[0].cyc, last_acc8 + 2);
            end
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (got8[k].data !== W'(head[k])) begin
                    n_fail++;
                    $display("FAIL raster8_head[%0d]: got %0d want %0d", k, got8[k].data, head[k]);
                end
            end
            for (int k = 0; k < 64; k++) begin
                n_checks++;
                if (got8[k].data !== exp8[k].data || got8[k].idx != k || got8[k].last != (k == 63)) begin
                    n_fail++;
                    $display("FAIL raster8_beat[%0d]: data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                             k, got8[k].data, got8[k].idx, got8[k].last, exp8[k].data, k, (k == 63));
                end
            end
        end
        clear8();
    endtask

    task automatic test_raster4();
        int exp_lit [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
        int last4;
        int t;
        last4 = 0;
        align();
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            int w;
            w = 0;
            bus4.in_valid = 1'b1;
            bus4.in_data  = W'(i);
            @(negedge clk);
            while (!bus4.in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            last4 = cyc;
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        t = 0;
        while (got4.size() < 16 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (got4.size() != 16) begin
            n_fail++;
            $display("FAIL raster4_count: got %0d outputs, want 16", got4.size());
        end else begin
            n_checks++;
            if (got4[0].cyc != last4 + 2) begin
                n_fail++;
                $display("FAIL raster4_latency: first out_valid in cycle %0d, want %0d", got4[0].cyc, last4 + 2);
            end
            for (int k = 0; k < 16; k++) begin
                n_checks++;
                if (got4[k].data !== W'(exp_lit[k]) || got4[k].data !== W'(ref_zz(4, k)) ||
                    got4[k].idx != k || got4[k].last != (k == 15)) begin
                    n_fail++;
                    $display("FAIL raster4_beat[%0d]: data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                             k, got4[k].data, got4[k].idx, got4[k].last, exp_lit[k], k, (k == 15));
                end
            end
        end
        got4.delete();
    endtask

    task automatic test_back_to_back();
        int w;
        int worst;
        bit ok;
        worst = 0;
        align();
        bus8.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) blk8[i] = W'($urandom);
            send_block8(0, w);
            if (w > worst) worst = w;
        end
        n_checks++;
        if (worst != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: in_ready low for %0d cycles, want 0", worst);
        end
        drain8(256, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, want 256", got8.size());
        end else begin
            for (int k = 0; k < 256; k++) begin
                n_checks++;
                if (got8[k].data !== exp8[k].data || got8[k].idx != exp8[k].idx ||
                    got8[k].last != exp8[k].last || got8[k].cyc != got8[0].cyc + k) begin
                    n_fail++;
                    $display("FAIL b2b_beat[%0d]: data=%0h idx=%0d last=%b cyc=%0d, want data=%0h idx=%0d last=%b cyc=%0d",
                             k, got8[k].data, got8[k].idx, got8[k].last, got8[k].cyc,
                             exp8[k].data, exp8[k].idx, exp8[k].last, got8[0].cyc + k);
                end
            end
        end
        clear8();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit prev_rdy;
        bit found;
        align();
        bus8.out_ready = 1'b0;
        acc8 = 0;
        push_done = 1'b0;
        fork
            begin
                int w;
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 64; i++) blk8[i] = W'($urandom);
                    send_block8(0, w);
                end
                push_done = 1'b1;
            end
        join_none
        repeat (200) @(negedge clk);
        n_checks++;
        if (acc8 != 128 || bus8.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: accepted %0d in_ready=%b, want 128 0", acc8, bus8.in_ready);
        end
        n_checks++;
        if (bus8.out_valid !== 1'b1 || bus8.out_idx !== '0 || bus8.out_data !== exp8[0].data) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b idx=%0d data=%0h, want 1 0 %0h",
                     bus8.out_valid, bus8.out_idx, bus8.out_data, exp8[0].data);
        end
        align();
        bus8.out_ready = 1'b1;
        prev_rdy = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus8.out_valid && bus8.out_idx == 6'd63) begin
                found = 1'b1;
                n_checks++;
                if (bus8.in_ready !== 1'b1 || prev_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_release: in_ready=%b prev=%b at last-element cycle, want 1 0", bus8.in_ready, prev_rdy);
                end
            end
            prev_rdy = bus8.in_ready;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_release_timeout: last element of block 0 not seen, want seen");
        end
        for (int t = 0; t < 3000 && !push_done; t++) @(negedge clk);
        drain8(192, ok);
        n_checks++;
        if (!ok || !push_done) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs done=%b, want 192 1", got8.size(), push_done);
        end else begin
            for (int k = 0; k < 192; k++) begin
                n_checks++;
                if (got8[k].data !== exp8[k].data || got8[k].idx != exp8[k].idx || got8[k].last != exp8[k].last) begin
                    n_fail++;
                    $display("FAIL bp_beat[%0d]: data=%0h idx=%0d, want data=%0h idx=%0d",
                             k, got8[k].data, got8[k].idx, exp8[k].data, exp8[k].idx);
                end
            end
        end
        clear8();
    endtask

    task automatic test_reset_midblock();
        int w;
        bit ok;
        align();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) push8(W'($urandom), w);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_data !== '0 ||
            bus8.out_idx !== '0 || bus8.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: in_ready=%b out_valid=%b data=%0h idx=%0d last=%b, want 1 0 0 0 0",
                     bus8.in_ready, bus8.out_valid, bus8.out_data, bus8.out_idx, bus8.out_last);
        end
        align();
        rst_n = 1'b1;
        clear8();
        for (int i = 0; i < 64; i++) blk8[i] = W'($urandom);
        send_block8(0, w);
        drain8(64, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d outputs, want 64", got8.size());
        end else begin
            for (int k = 0; k < 64; k++) begin
                n_checks++;
                if (got8[k].data !== exp8[k].data || got8[k].idx != k || got8[k].last != (k == 63)) begin
                    n_fail++;
                    $display("FAIL midreset_beat[%0d]: data=%0h idx=%0d, want data=%0h idx=%0d",
                             k, got8[k].data, got8[k].idx, exp8[k].data, k);
                end
            end
        end
        clear8();
    endtask

    task automatic test_random_flow();
        bit ok;
        align();
        push_done = 1'b0;
        fork
            begin
                int w;
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 64; i++)
                        blk8[i] = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
                    send_block8(2, w);
                end
                push_done = 1'b1;
            end
            begin
                for (int t = 0; t < 5000 && !push_done; t++) begin
                    align();
                    bus8.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        align();
        bus8.out_ready = 1'b1;
        drain8(192, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_count: got %0d outputs, want 192", got8.size());
        end else begin
            for (int k = 0; k < 192; k++) begin
                n_checks++;
                if (got8[k].data !== exp8[k].data || got8[k].idx != exp8[k].idx || got8[k].last != exp8[k].last
`ifdef ZIGZAG_EOB_EN
                    || got8[k].eob != exp8[k].eob || got8[k].zero != exp8[k].zero
`endif
                    ) begin
                    n_fail++;
                    $display("FAIL rand_beat[%0d]: data=%0h idx=%0d eob=%0d zero=%b, want data=%0h idx=%0d eob=%0d zero=%b",
                             k, got8[k].data, got8[k].idx, got8[k].eob, got8[k].zero,
                             exp8[k].data, exp8[k].idx, exp8[k].eob, exp8[k].zero);
                end
            end
        end
        clear8();
    endtask

`ifdef ZIGZAG_EOB_EN
    task automatic test_eob();
        int w;
        bit ok;
        int lit_eob [3] = '{4, 0, 63};
        bit lit_zero [3] = '{1'b0, 1'b1, 1'b0};
        align();
        bus8.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 64; i++) blk8[i] = '0;
            if (b == 0) blk8[9]  = W'(5);
            if (b == 2) blk8[63] = W'($urandom_range(1, 4095));
            send_block8(0, w);
        end
        drain8(192, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL eob_count: got %0d outputs, want 192", got8.size());
        end else begin
            for (int b = 0; b < 3; b++) begin
                n_checks++;
                if (got8[b * 64].eob != lit_eob[b] || got8[b * 64].zero != lit_zero[b]) begin
                    n_fail++;
                    $display("FAIL eob_block%0d: eob=%0d zero=%b, want %0d %b",
                             b, got8[b * 64].eob, got8[b * 64].zero, lit_eob[b], lit_zero[b]);
                end
            end
            for (int k = 0; k < 192; k++) begin
                n_checks++;
                if (got8[k].eob != exp8[k].eob || got8[k].zero != exp8[k].zero || got8[k].data !== exp8[k].data) begin
                    n_fail++;
                    $display("FAIL eob_beat[%0d]: eob=%0d zero=%b data=%0h, want %0d %b %0h",
                             k, got8[k].eob, got8[k].zero, got8[k].data, exp8[k].eob, exp8[k].zero, exp8[k].data);
                end
            end
        end
        clear8();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.out_ready = 1'b1;
        test_reset();
        test_raster8();
        test_raster4();
        test_back_to_back();
        test_backpressure();
        test_reset_midblock();
`ifdef ZIGZAG_EOB_EN
        test_eob();
`endif
        test_random_flow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
